// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// first-word-fall-through receive FIFO with sticky framing/overrun flags.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx,
   input  logic                          rd_en,
   output logic [7:0]                    rd_data,
   output logic                          rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          err_clr
);
   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CTW = PW + 1;
   localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CTW-1:0] DEPTH_C = CTW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   logic          sync1_q, rx_s_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          push, frame_evt;

   logic [7:0]     mem_q [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CTW-1:0] count_q, count_d;
   logic           pop, push_ok, drop;
   logic           frame_err_q, overrun_q;

   // Synchronizer presets high so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= rx;
         rx_s_q  <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      bit_d     = bit_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_evt = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (!rx_s_q) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               state_d = rx_s_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_evt = 1'b1;
                  state_d   = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            cnt_d = '0;
            if (rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
   assign pop     = rd_en && (count_q != '0);
   assign push_ok = push && ((count_q != DEPTH_C) || pop);
   assign drop    = push && (count_q == DEPTH_C) && !pop;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CTW'(1);
         2'b01:   count_d = count_q - CTW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q     <= count_d;
         frame_err_q <= (frame_err_q && !err_clr) || frame_evt;
         overrun_q   <= (overrun_q && !err_clr) || drop;
      end
   end

   // Storage is not reset, so the head is masked to zero while empty.
   assign rd_data    = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
   assign rx_valid   = (count_q != '0);
   assign fifo_count = count_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame table, hand-timed corner sequences and random
// frames checked against a queue-based receiver model.
module tb_uart_rx;
   localparam int CPB      = 16;
   localparam int DEPTH    = 4;
   localparam int IDLE_GAP = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       rd_en;
   logic       err_clr;
   logic [7:0] rd_data;
   logic       rx_valid;
   logic [2:0] fifo_count;
   logic       frame_err;
   logic       overrun;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] model_q[$];
   logic       model_fe;
   logic       model_ov;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_count;
      logic [7:0] exp_head;
      logic       exp_fe;
      logic       exp_ov;
   } vec_t;

   vec_t table_v[6];

   uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en),
      .rd_data(rd_data), .rx_valid(rx_valid), .fifo_count(fifo_count),
      .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop;
      tick(CPB);
      rx = 1'b1;
      tick(IDLE_GAP);
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   task automatic clr_pulse();
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
   endtask

   task automatic compare_model(input string name);
      check({name, "_count"}, 32'(fifo_count), 32'(model_q.size()));
      check({name, "_valid"}, 32'(rx_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) check({name, "_head"}, 32'(rd_data), 32'(model_q[0]));
      check({name, "_fe"}, 32'(frame_err), 32'(model_fe));
      check({name, "_ov"}, 32'(overrun), 32'(model_ov));
   endtask

   initial begin
      logic [7:0] rb;
      logic       rstop;
      int         npop;

      table_v[0] = '{8'hA5, 1'b1, 1, 8'hA5, 1'b0, 1'b0};
      table_v[1] = '{8'h3C, 1'b0, 1, 8'hA5, 1'b1, 1'b0};
      table_v[2] = '{8'h55, 1'b1, 2, 8'hA5, 1'b1, 1'b0};
      table_v[3] = '{8'h01, 1'b1, 3, 8'hA5, 1'b1, 1'b0};
      table_v[4] = '{8'h02, 1'b1, 4, 8'hA5, 1'b1, 1'b0};
      table_v[5] = '{8'h03, 1'b1, 4, 8'hA5, 1'b1, 1'b1};

      rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
      tick(3);
      check("reset_rd_data", 32'(rd_data), 32'h00);
      check("reset_valid", 32'(rx_valid), 0);
      check("reset_count", 32'(fifo_count), 0);
      check("reset_fe", 32'(frame_err), 0);
      check("reset_ov", 32'(overrun), 0);
      rst_n = 1'b1;
      tick(4);

      // Table of frames applied back to back without reads
      for (int i = 0; i < 6; i++) begin
         send_byte(table_v[i].data, table_v[i].stop);
         check($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(table_v[i].exp_count));
         check($sformatf("tbl%0d_head", i), 32'(rd_data), 32'(table_v[i].exp_head));
         check($sformatf("tbl%0d_fe", i), 32'(frame_err), 32'(table_v[i].exp_fe));
         check($sformatf("tbl%0d_ov", i), 32'(overrun), 32'(table_v[i].exp_ov));
      end
      check("drain_h0", 32'(rd_data), 32'hA5); pop_one();
      check("drain_h1", 32'(rd_data), 32'h55); pop_one();
      check("drain_h2", 32'(rd_data), 32'h01); pop_one();
      check("drain_h3", 32'(rd_data), 32'h02); pop_one();
      check("drain_empty", 32'(rx_valid), 0);
      pop_one();
      check("pop_empty_count", 32'(fifo_count), 0);
      clr_pulse();
      check("clr_fe", 32'(frame_err), 0);
      check("clr_ov", 32'(overrun), 0);

      // Exact latency from the rx falling edge to rx_valid
      fork
         send_byte(8'hA5, 1'b1);
         begin
            tick(154);
            check("lat_before", 32'(rx_valid), 0);
            tick(1);
            check("lat_at", 32'(rx_valid), 1);
            check("lat_data", 32'(rd_data), 32'hA5);
            check("lat_count", 32'(fifo_count), 1);
         end
      join
      pop_one();
      check("lat_pop_valid", 32'(rx_valid), 0);
      check("lat_pop_count", 32'(fifo_count), 0);

      // Short glitch on the line is rejected as a false start
      rx = 1'b0; tick(4); rx = 1'b1; tick(2 * CPB);
      check("glitch_valid", 32'(rx_valid), 0);
      check("glitch_fe", 32'(frame_err), 0);
      check("glitch_count", 32'(fifo_count), 0);

      // Same-cycle pop and push on a full FIFO
      send_byte(8'h10, 1'b1); send_byte(8'h11, 1'b1);
      send_byte(8'h12, 1'b1); send_byte(8'h13, 1'b1);
      check("full_count", 32'(fifo_count), 4);
      fork
         send_byte(8'h99, 1'b1);
         begin
            tick(154);
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
         end
      join
      check("pp_ov", 32'(overrun), 0);
      check("pp_count", 32'(fifo_count), 4);
      check("pp_h0", 32'(rd_data), 32'h11); pop_one();
      check("pp_h1", 32'(rd_data), 32'h12); pop_one();
      check("pp_h2", 32'(rd_data), 32'h13); pop_one();
      check("pp_h3", 32'(rd_data), 32'h99); pop_one();
      check("pp_empty", 32'(rx_valid), 0);

      // Asynchronous reset in the middle of a frame
      send_byte(8'h3C, 1'b0);
      send_byte(8'h77, 1'b1);
      fork
         send_byte(8'hF0, 1'b1);
         begin
            tick(60);
            rst_n = 1'b0;
            #1;
            check("mid_rst_count", 32'(fifo_count), 0);
            check("mid_rst_valid", 32'(rx_valid), 0);
            check("mid_rst_data", 32'(rd_data), 32'h00);
            check("mid_rst_fe", 32'(frame_err), 0);
            check("mid_rst_ov", 32'(overrun), 0);
         end
      join
      tick(2);
      rst_n = 1'b1;
      tick(4);
      send_byte(8'h0F, 1'b1);
      check("post_rst_count", 32'(fifo_count), 1);
      check("post_rst_data", 32'(rd_data), 32'h0F);
      pop_one();

      // Random frames against the queue model
      model_q.delete();
      model_fe = 1'b0;
      model_ov = 1'b0;
      for (int n = 0; n < 24; n++) begin
         rb = 8'($urandom);
         rstop = ($urandom_range(0, 7) != 0);
         send_byte(rb, rstop);
         if (!rstop) model_fe = 1'b1;
         else if (model_q.size() < DEPTH) model_q.push_back(rb);
         else model_ov = 1'b1;
         compare_model($sformatf("rnd%0d", n));
         npop = int'($urandom_range(0, 2));
         for (int k = 0; k < npop; k++) begin
            pop_one();
            if (model_q.size() != 0) void'(model_q.pop_front());
         end
         compare_model($sformatf("rnd%0d_pop", n));
         if ($urandom_range(0, 5) == 0) begin
            clr_pulse();
            model_fe = 1'b0;
            model_ov = 1'b0;
            compare_model($sformatf("rnd%0d_clr", n));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial 8N1 UART receiver: the receive-side counterpart of the SoC UART transmitter.
- Samples an asynchronous serial line and reassembles bytes.
- Buffers bytes in a small first-word-fall-through FIFO.
- Exposes the FIFO head and sticky error flags for the MMIO read path in the UART window (0x1000_0000..0x1000_00FF), so monitor code can poll and pop received characters.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be an even integer ≥ 4.
- FIFO_DEPTH, 4: receive FIFO entries. Must be a power of two ≥ 2.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- rx  in  1  serial input. Idle high. Asynchronous to clk.
- rd_en  in  1  pop FIFO head. One entry per cycle while asserted.
- rd_data  out  8  FIFO head byte. Valid when rx_valid=1.
- rx_valid  out  1  FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- err_clr  in  1  clear both sticky flags.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM to IDLE; bit and sample counters to 0.
  - FIFO empty. rd_data=0x00, rx_valid=0, fifo_count=0, frame_err=0, overrun=0.
  - Synchronizer flops preset to 1, so no false start after release.
  - Reset mid-frame discards the partial byte.
- Input sync: rx passes through 2 flops; rx_s is the synced value. All FSM decisions use rx_s only.
- FSM states IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on rx_s=0, go to START with counter cleared.
  - START: at count CLKS_PER_BIT/2−1 (mid start bit), sample rx_s.
    - rx_s=1: false start, return to IDLE.
    - rx_s=0: go to DATA, counter reset.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit). Shift into bit 7 of the shift register, LSB first. After the 8th sample, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx_s=1: push byte, go to IDLE.
    - rx_s=0: set frame_err, discard byte, go to WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s=1 (break/line-low tolerance), then go to IDLE.
- Latency: rx_valid rises exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx falling edge. With default CLKS_PER_BIT=16 this is 155 cycles.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - First-word fall-through: rd_data is the head combinationally from storage and changes on the cycle after a pop.
  - rd_en while empty: ignored; no pointer movement, no error.
  - Push while full without same-cycle pop: byte dropped, overrun set.
  - Push and pop in the same cycle when full: pop first, then push accepted. Count stays FIFO_DEPTH; overrun not set.
  - Push and pop in the same cycle when count=1: count stays 1; rd_data shows the new byte next cycle.
- Sticky flags:
  - err_clr clears both flags.
  - An error event in the same cycle as err_clr wins: the flag reads 1 next cycle.
- No parity support. No runtime baud change; CLKS_PER_BIT is elaboration-time only.

Test Plan:
- Byte 0xA5 at 16 clk/bit, rd_en held 0 -> rx_valid=1 at cycle 155 after the falling edge, rd_data=0xA5, fifo_count=1. Pulse rd_en once -> rx_valid=0, fifo_count=0.
- rx low for 4 cycles then high (glitch) -> FSM returns to IDLE. No push; rx_valid stays 0; frame_err stays 0.
- Byte 0x3C with stop bit driven 0, then line high -> frame_err=1, fifo_count=0. A following valid byte 0x55 is received normally. err_clr pulse -> frame_err=0.
- Five bytes 0x01..0x05 with no reads (depth 4) -> fifo_count=4, overrun=1. Pops return 0x01, 0x02, 0x03, 0x04, then rx_valid=0.
- FIFO full; rd_en asserted on the exact cycle 0x99 is pushed -> overrun stays 0, fifo_count=4. Subsequent pops end with 0x99 (wrap-around verified).
- rst_n pulsed low mid-DATA of byte 0xF0 -> all outputs at reset values immediately (asynchronous). Next byte 0x0F is received correctly with no spurious byte.
